// File: rtl/button_count_ctrl.sv
// Three-button up/down/clear counter. Each raw button is synchronized, and one
// FSM owns debounce, auto-repeat and release detection for whichever button wins
// arbitration.
module button_count_ctrl #(
  parameter int DEBOUNCE     = 300000,
  parameter int REPEAT_DELAY = 15000000,
  parameter int REPEAT_RATE  = 3000000,
  parameter bit WRAP         = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       btn_clr,
  output logic [7:0] count,
  output logic       step,
  output logic       limit,
  output logic       busy
);

  // The shared timer only has to reach (largest parameter - 1), because every
  // state change reloads it to zero.
  localparam int MAX_AB = (DEBOUNCE > REPEAT_DELAY) ? DEBOUNCE : REPEAT_DELAY;
  localparam int MAXP   = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
  localparam int TW     = (MAXP < 2) ? 1 : $clog2(MAXP);

  localparam logic [TW-1:0] DEB_M1 = TW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] DLY_M1 = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RAT_M1 = TW'(REPEAT_RATE - 1);

  typedef enum logic [2:0] {S_IDLE, S_DEBOUNCE, S_FIRE, S_HOLD, S_RELEASE} state_t;
  typedef enum logic [1:0] {G_NONE, G_UP, G_DN, G_CLR} grant_t;

  // Bit order {clr, dn, up}.
  logic [2:0]    sync_a, sync_b;
  state_t        state, state_n;
  grant_t        gnt, gnt_n;
  logic [TW-1:0] timer, timer_n;
  logic          rpt, rpt_n;
  logic          gnt_lvl;
  logic [TW-1:0] hold_m1;

  // Two-flop synchronizer for each raw button.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {btn_clr, btn_dn, btn_up};
      sync_b <= sync_a;
    end
  end

  // Select the synchronized level of the granted button.
  always_comb begin
    case (gnt)
      G_UP:    gnt_lvl = sync_b[0];
      G_DN:    gnt_lvl = sync_b[1];
      G_CLR:   gnt_lvl = sync_b[2];
      default: gnt_lvl = 1'b0;
    endcase
  end

  // The first repeat of a press waits the long delay. Later repeats use the rate.
  assign hold_m1 = rpt ? RAT_M1 : DLY_M1;

  // Register the FSM state, timer, grant and repeat flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      gnt   <= G_NONE;
      timer <= '0;
      rpt   <= 1'b0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      timer <= timer_n;
      rpt   <= rpt_n;
    end
  end

  // Next-state logic. The timer counts by default and reloads on every transition.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    rpt_n   = rpt;
    timer_n = timer + 1'b1;
    case (state)
      S_IDLE: begin
        timer_n = '0;
        rpt_n   = 1'b0;
        // Up and dn together with no clear are ambiguous, so nothing is granted.
        if (sync_b[2]) begin
          gnt_n   = G_CLR;
          state_n = S_DEBOUNCE;
        end else if (sync_b[0] && !sync_b[1]) begin
          gnt_n   = G_UP;
          state_n = S_DEBOUNCE;
        end else if (sync_b[1] && !sync_b[0]) begin
          gnt_n   = G_DN;
          state_n = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (!gnt_lvl) begin
          state_n = S_IDLE;
          timer_n = '0;
        end else if (timer == DEB_M1) begin
          state_n = S_FIRE;
          timer_n = '0;
        end
      end
      S_FIRE: begin
        timer_n = '0;
        state_n = (gnt == G_CLR) ? S_RELEASE : S_HOLD;
      end
      S_HOLD: begin
        if (!gnt_lvl) begin
          state_n = S_RELEASE;
          timer_n = '0;
        end else if (timer == hold_m1) begin
          state_n = S_FIRE;
          timer_n = '0;
          rpt_n   = 1'b1;
        end
      end
      S_RELEASE: begin
        if (|sync_b) begin
          timer_n = '0;
        end else if (timer == DEB_M1) begin
          state_n = S_IDLE;
          timer_n = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
        timer_n = '0;
      end
    endcase
  end

  // Apply the granted action in FIRE. Also raise step, and raise limit when the
  // count wraps or saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      step  <= 1'b0;
      limit <= 1'b0;
    end else begin
      step  <= 1'b0;
      limit <= 1'b0;
      if (state == S_FIRE) begin
        step <= 1'b1;
        case (gnt)
          G_UP: begin
            if (count == 8'hFF) begin
              limit <= 1'b1;
              if (WRAP) count <= 8'h00;
            end else begin
              count <= count + 8'd1;
            end
          end
          G_DN: begin
            if (count == 8'h00) begin
              limit <= 1'b1;
              if (WRAP) count <= 8'hFF;
            end else begin
              count <= count - 8'd1;
            end
          end
          G_CLR:   count <= 8'h00;
          default: ;
        endcase
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_button_count_ctrl.sv
// Scoreboard bench for button_count_ctrl. One wrapping instance and one
// saturating instance receive the same button stimulus. Expected step events
// (cycle, count, limit) are computed from the press timing and checked when
// step rises.
module tb_button_count_ctrl;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic btn_up, btn_dn, btn_clr;
  logic [7:0] count_w, count_s;
  logic step_w, step_s, limit_w, limit_s, busy_w, busy_s;

  always #5 clk = ~clk;

  button_count_ctrl #(.DEBOUNCE(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset_n(reset_n), .btn_up(btn_up), .btn_dn(btn_dn), .btn_clr(btn_clr),
    .count(count_w), .step(step_w), .limit(limit_w), .busy(busy_w));

  button_count_ctrl #(.DEBOUNCE(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .WRAP(1'b0)) dut_s (
    .clk(clk), .reset_n(reset_n), .btn_up(btn_up), .btn_dn(btn_dn), .btn_clr(btn_clr),
    .count(count_s), .step(step_s), .limit(limit_s), .busy(busy_s));

  typedef struct {
    int cyc;
    int cnt;
    int lim;
  } exp_t;

  exp_t q_w[$];
  exp_t q_s[$];
  int   mdl_w = 0;
  int   mdl_s = 0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected updates for a press held for h cycles, starting at the negedge
  // after posedge t0. The first sampling edge is E0 = t0+1. The first update
  // lands at E0+DEB+3, then after RD+1 cycles, then every RR+1 cycles.
  // Repeats continue while the button is still seen at the repeat decision
  // point, that is for updates up to E0+h+2.
  function automatic void push_press(input bit u, input bit d, input bit c,
                                     input int t0, input int h);
    int act;
    int e0;
    int ue;
    int k;
    int lw;
    int ls;
    if (c) act = 2;
    else if (u && !d) act = 1;
    else if (d && !u) act = -1;
    else return;
    e0 = t0 + 1;
    ue = e0 + DEB + 3;
    k  = 0;
    while (ue <= e0 + h + 2) begin
      lw = 0;
      ls = 0;
      if (act == 2) begin
        mdl_w = 0;
        mdl_s = 0;
      end else if (act == 1) begin
        lw = (mdl_w == 255);
        mdl_w = (mdl_w + 1) % 256;
        ls = (mdl_s == 255);
        if (!ls) mdl_s = mdl_s + 1;
      end else begin
        lw = (mdl_w == 0);
        mdl_w = (mdl_w + 255) % 256;
        ls = (mdl_s == 0);
        if (!ls) mdl_s = mdl_s - 1;
      end
      q_w.push_back('{ue, mdl_w, lw});
      q_s.push_back('{ue, mdl_s, ls});
      if (act == 2) break;
      ue = ue + ((k == 0) ? RD + 1 : RR + 1);
      k++;
    end
  endfunction

  // Check each step pulse against the next expected event.
  always @(negedge clk) begin : mon
    exp_t e;
    if (step_w) begin
      if (q_w.size() == 0) chk("w_unexpected_step", cyc, -1);
      else begin
        e = q_w.pop_front();
        chk("w_step_cycle", cyc, e.cyc);
        chk("w_count", int'(count_w), e.cnt);
        chk("w_limit", int'(limit_w), e.lim);
      end
    end else if (limit_w) chk("w_limit_without_step", int'(limit_w), 0);
    if (step_s) begin
      if (q_s.size() == 0) chk("s_unexpected_step", cyc, -1);
      else begin
        e = q_s.pop_front();
        chk("s_step_cycle", cyc, e.cyc);
        chk("s_count", int'(count_s), e.cnt);
        chk("s_limit", int'(limit_s), e.lim);
      end
    end else if (limit_s) chk("s_limit_without_step", int'(limit_s), 0);
  end

  task automatic press(input bit u, input bit d, input bit c, input int h);
    push_press(u, d, c, cyc, h);
    btn_up = u; btn_dn = d; btn_clr = c;
    repeat (h) @(negedge clk);
    btn_up = 1'b0; btn_dn = 1'b0; btn_clr = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while ((busy_w || busy_s) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("busy_returns_low", int'(busy_w | busy_s), 0);
    repeat (2) @(negedge clk);
    chk("w_count_idle", int'(count_w), mdl_w);
    chk("s_count_idle", int'(count_s), mdl_s);
  endtask

  initial begin : main
    int t0;
    int tr;
    reset_n = 1'b0;
    btn_up = 1'b0; btn_dn = 1'b0; btn_clr = 1'b0;
    #1;
    chk("rst_count_w", int'(count_w), 0);
    chk("rst_count_s", int'(count_s), 0);
    chk("rst_step", int'(step_w | step_s), 0);
    chk("rst_limit", int'(limit_w | limit_s), 0);
    chk("rst_busy", int'(busy_w | busy_s), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // dn at 0: the wrapping instance goes to 255, the saturating one holds 0. Both raise limit.
    press(0, 1, 0, 10); settle();
    // up: the wrapping instance goes 255 -> 0 with limit, the saturating one goes 0 -> 1.
    press(1, 0, 0, 10); settle();
    // Hold up: updates at E7, E18, E22, E26.
    press(1, 0, 0, 26); settle();
    // A 3-cycle glitch does nothing.
    press(1, 0, 0, 3); settle();
    // Clear, then clear again at 0: step fires, limit stays low.
    press(0, 0, 1, 10); settle();
    press(0, 0, 1, 10); settle();
    // Long hold up to 255 on both, then one more up: wrap versus saturate.
    press(1, 0, 0, 1030); settle();
    press(1, 0, 0, 10); settle();

    // Count to 9. up+dn together grants nothing. Adding clr clears once.
    press(0, 0, 1, 10); settle();
    press(1, 0, 0, 46); settle();
    btn_up = 1'b1; btn_dn = 1'b1;
    repeat (12) @(negedge clk);
    chk("updn_busy", int'(busy_w | busy_s), 0);
    chk("updn_count", int'(count_w), 9);
    push_press(1, 1, 1, cyc, 20);
    btn_clr = 1'b1;
    repeat (20) @(negedge clk);
    btn_up = 1'b0; btn_dn = 1'b0; btn_clr = 1'b0;
    repeat (5) @(negedge clk);
    chk("release_busy_hi_w", int'(busy_w), 1);
    chk("release_busy_hi_s", int'(busy_s), 1);
    @(negedge clk);
    chk("release_busy_lo", int'(busy_w | busy_s), 0);
    settle();

    // Reset during HOLD at count 5, then release reset with up still held.
    press(0, 0, 1, 10); settle();
    t0 = cyc;
    push_press(1, 0, 0, t0, 30);
    btn_up = 1'b1;
    repeat (32) @(negedge clk);
    chk("pre_reset_count", int'(count_w), 5);
    chk("pre_reset_busy", int'(busy_w), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_count", int'(count_w) + int'(count_s), 0);
    chk("mid_reset_busy", int'(busy_w | busy_s), 0);
    mdl_w = 0; mdl_s = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    tr = cyc;
    push_press(1, 0, 0, tr, 10);
    repeat (10) @(negedge clk);
    btn_up = 1'b0;
    settle();
    chk("post_reset_count", int'(count_w), 1);

    chk("w_queue_empty", q_w.size(), 0);
    chk("s_queue_empty", q_s.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/button_count_ctrl.md
BUTTON_COUNT_CTRL -- requirements
Module: button_count_ctrl

Interface
REQ-001 Parameter DEBOUNCE, default 300000: consecutive stable cycles required to accept a press or a release.
REQ-002 Parameter REPEAT_DELAY, default 15000000: hold cycles before the first auto-repeat.
REQ-003 Parameter REPEAT_RATE, default 3000000: hold cycles between subsequent auto-repeats.
REQ-004 Parameter WRAP, default 1: 1 = modulo-256 counting, 0 = saturate at 0 and 255.
REQ-005 clk  input  1  single system clock, all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 btn_up  input  1  raw increment button, asynchronous, active-high.
REQ-008 btn_dn  input  1  raw decrement button, asynchronous, active-high.
REQ-009 btn_clr  input  1  raw clear button, asynchronous, active-high.
REQ-010 count  output  8  registered counter value.
REQ-011 step  output  1  one-cycle pulse, high in the cycle after any count action is applied.
REQ-012 limit  output  1  one-cycle pulse coincident with step when the action wrapped (WRAP=1) or was blocked by saturation (WRAP=0).
REQ-013 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 Each button SHALL pass through its own 2-flop synchronizer; the FSM SHALL see only synchronized levels.
REQ-015 The FSM SHALL have states IDLE, DEBOUNCE, FIRE, HOLD, RELEASE, plus one shared timer wide enough for the largest parameter.
REQ-016 IDLE: the FSM SHALL grant by priority clr > up > dn, latch the grant, clear the timer, and go to DEBOUNCE.
REQ-017 IDLE: if up and dn are both high and clr is low, the FSM SHALL grant nothing and remain in IDLE.
REQ-018 DEBOUNCE: if the granted button drops, the FSM SHALL return to IDLE with no action.
REQ-019 DEBOUNCE: when the timer reaches DEBOUNCE-1, the FSM SHALL go to FIRE.
REQ-020 FIRE (exactly one cycle): the FSM SHALL apply the granted action (up +1, dn -1, clr to 0) and clear the timer.
REQ-021 FIRE exit: up/dn SHALL go to HOLD; clr SHALL go to RELEASE.
REQ-022 HOLD: if the granted button drops, the FSM SHALL go to RELEASE.
REQ-023 HOLD: when the timer reaches limit-1, the FSM SHALL go to FIRE, where limit is REPEAT_DELAY for the first repeat of a press and REPEAT_RATE thereafter.
REQ-024 HOLD: non-granted buttons SHALL be ignored.
REQ-025 RELEASE: the FSM SHALL return to IDLE only after all three synchronized buttons are low for DEBOUNCE consecutive cycles; any high SHALL restart the timer.
REQ-026 With WRAP=1, 255+1 SHALL give 0 and 0-1 SHALL give 255, each with a limit pulse.
REQ-027 With WRAP=0, 255+1 and 0-1 SHALL leave count unchanged, with both step and limit pulsed.
REQ-028 clr SHALL pulse step even when count is already 0; clr SHALL never pulse limit.
REQ-029 Latency: for a single press held from the first sampling edge E0, count SHALL update at edge E0+DEBOUNCE+3, and step SHALL be high in the following cycle.
REQ-030 Auto-repeat period: the first repeat SHALL occur REPEAT_DELAY+1 cycles after the first update, and later repeats every REPEAT_RATE+1 cycles.

Reset
REQ-031 While reset_n is low: count=0, step=0, limit=0, busy=0, FSM=IDLE, and timer, grant, synchronizers and repeat flag cleared, all immediately (asynchronous).
REQ-032 Reset asserted mid-DEBOUNCE, HOLD or RELEASE SHALL abort the sequence with no further count action.
REQ-033 After deassertion, a button still held SHALL be treated as a new press.

Verification (DEBOUNCE=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-034 Hold btn_up from E0 -> count 0->1 at E7; then 2 at E18, 3 at E22, 4 at E26; step high for one cycle after each update.
REQ-035 btn_up pulse of 3 cycles -> no count change, step never asserts, busy returns low.
REQ-036 count=255, WRAP=1, press up -> count=0 with step and limit. Same with WRAP=0 -> count stays 255, step and limit pulsed. count=0, WRAP=0, press dn -> count stays 0, step and limit pulsed.
REQ-037 count=9, press btn_up and btn_dn together -> no change; add btn_clr -> count=0 once with no repeat, and busy stays high until all buttons are low for 4 cycles.
REQ-038 Drop reset_n during HOLD with count=5 -> count=0 and busy=0 immediately; release reset with btn_up still held -> count=1 after a full debounce.
